// File: rtl/ddr_pkg.sv
// Shared state encoding, command opcode and requester indices for the DDR read scheduler.
package ddr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic [2:0] CMD_READ = 3'b001;

  localparam int   NUM_REQ = 2;
  localparam logic REQ_VGA = 1'b0;
  localparam logic REQ_USB = 1'b1;

endpackage

// File: rtl/ddr_rd_sched_if.sv
// DDR command-port bundle between the read scheduler (master) and the memory controller (slave).
interface ddr_rd_sched_if #(
  parameter int ADDR_W = 30
);

  logic              cmd_full;
  logic              cmd_en;
  logic [2:0]        cmd_instr;
  logic [5:0]        cmd_bl;
  logic [ADDR_W-1:0] cmd_addr;

  modport master (
    input  cmd_full,
    output cmd_en, cmd_instr, cmd_bl, cmd_addr
  );

  modport slave (
    output cmd_full,
    input  cmd_en, cmd_instr, cmd_bl, cmd_addr
  );

endinterface

// File: rtl/ddr_addr_gen.sv
// Per-requester burst pointer: rewinds to BASE on set, otherwise steps by STEP and wraps at
// BASE+FRAME_BYTES.
module ddr_addr_gen #(
  parameter int                ADDR_W      = 30,
  parameter logic [ADDR_W-1:0] BASE        = '0,
  parameter int                STEP        = 512,
  parameter int                FRAME_BYTES = 1843200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic              adv,
  output logic [ADDR_W-1:0] ptr
);

  // One extra bit so the wrap compare cannot overflow near the top of the address space.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(BASE) + (ADDR_W+1)'(FRAME_BYTES);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   nxt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nxt   = (ADDR_W+1)'(ptr_q) + (ADDR_W+1)'(STEP);
    ptr_d = ptr_q;
    if (set) begin
      ptr_d = BASE;
    end else if (adv) begin
      ptr_d = (nxt >= LIMIT) ? BASE : nxt[ADDR_W-1:0];
    end
  end

  // NOTE: state flops use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= BASE;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ddr_rd_sched.sv
// Two-requester (VGA, USB) DDR read-burst scheduler with IDLE/ISSUE/GAP command pacing.
// Define DDR_RD_SCHED_RR_EN for round-robin arbitration; default is fixed VGA priority.
module ddr_rd_sched
  import ddr_pkg::*;
#(
  parameter int                ADDR_W      = 30,
  parameter int                BURST_LEN   = 64,
  parameter logic [ADDR_W-1:0] VGA_BASE    = '0,
  parameter logic [ADDR_W-1:0] USB_BASE    = '0,
  parameter int                FRAME_BYTES = 1843200
) (
  input  logic           vga_clk,
  input  logic           vga_rst,
  input  logic           vga_req,
  input  logic           vga_addr_set,
  input  logic           usb_req,
  input  logic           usb_addr_set,
  ddr_rd_sched_if.master cmd,
  output logic           vga_gnt,
  output logic           usb_gnt,
  output logic           busy,
  output logic           drop_err
);

  state_e             state_q, state_d;
  logic               win_q, win_d;
  logic               pick, issue;
  logic               drop_q, drop_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] req, set, adv;
  logic [ADDR_W-1:0]  vga_ptr, usb_ptr;

  always_comb begin
    req          = '0;
    set          = '0;
    adv          = '0;
    req[REQ_VGA] = vga_req;
    req[REQ_USB] = usb_req;
    set[REQ_VGA] = vga_addr_set;
    set[REQ_USB] = usb_addr_set;
    adv[REQ_VGA] = issue && (win_q == REQ_VGA);
    adv[REQ_USB] = issue && (win_q == REQ_USB);
  end

  // A req in its own grant cycle re-arms instead of dropping; addr_set overrides everything.
  always_comb begin
    pend_d = pend_q;
    drop_d = drop_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (adv[i]) pend_d[i] = 1'b0;
      if (req[i]) begin
        if (pend_q[i] && !adv[i]) drop_d = 1'b1;
        pend_d[i] = 1'b1;
      end
      if (set[i]) pend_d[i] = 1'b0;
    end
  end

`ifdef DDR_RD_SCHED_RR_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (issue) last_d = win_q;
  end

  // Token starts at USB so VGA takes the first contested slot.
  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) last_q <= REQ_USB;
    else         last_q <= last_d;
  end

  assign pick = (pend_q[REQ_VGA] && pend_q[REQ_USB]) ? ~last_q
              : (pend_q[REQ_VGA] ? REQ_VGA : REQ_USB);
`else
  assign pick = pend_q[REQ_VGA] ? REQ_VGA : REQ_USB;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          state_d = ST_ISSUE;
          win_d   = pick;
        end
      end
      ST_ISSUE: begin
        if (!cmd.cmd_full) begin
          issue   = 1'b1;
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or posedge vga_rst) begin
    if (vga_rst) begin
      state_q <= ST_IDLE;
      win_q   <= REQ_VGA;
      pend_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  ddr_addr_gen #(
    .ADDR_W     (ADDR_W),
    .BASE       (VGA_BASE),
    .STEP       (BURST_LEN * 8),
    .FRAME_BYTES(FRAME_BYTES)
  ) u_vga_addr (
    .clk(vga_clk), .rst(vga_rst), .set(set[REQ_VGA]), .adv(adv[REQ_VGA]), .ptr(vga_ptr)
  );

  ddr_addr_gen #(
    .ADDR_W     (ADDR_W),
    .BASE       (USB_BASE),
    .STEP       (BURST_LEN * 8),
    .FRAME_BYTES(FRAME_BYTES)
  ) u_usb_addr (
    .clk(vga_clk), .rst(vga_rst), .set(set[REQ_USB]), .adv(adv[REQ_USB]), .ptr(usb_ptr)
  );

  assign cmd.cmd_en    = issue;
  assign cmd.cmd_instr = CMD_READ;
  assign cmd.cmd_bl    = 6'(BURST_LEN - 1);
  assign cmd.cmd_addr  = (state_q != ST_ISSUE) ? '0
                       : ((win_q == REQ_USB) ? usb_ptr : vga_ptr);

  assign vga_gnt  = issue && (win_q == REQ_VGA);
  assign usb_gnt  = issue && (win_q == REQ_USB);
  assign busy     = (state_q != ST_IDLE) || (|pend_q);
  assign drop_err = drop_q;

endmodule

// File: tb/tb_ddr_rd_sched.sv
// Randomized self-checking bench for ddr_rd_sched against a transaction-level scheduling model.
module tb_ddr_rd_sched;

  localparam int ADDR_W      = 30;
  localparam int BURST_LEN   = 64;
  localparam int FRAME_BYTES = 1843200;
  localparam int BURSTS      = FRAME_BYTES / (BURST_LEN * 8);

  logic vga_clk = 1'b0;
  logic vga_rst = 1'b1;
  logic vga_req = 1'b0, vga_addr_set = 1'b0;
  logic usb_req = 1'b0, usb_addr_set = 1'b0;
  logic vga_gnt, usb_gnt, busy, drop_err;

  ddr_rd_sched_if #(.ADDR_W(ADDR_W)) cmd_if ();

  ddr_rd_sched #(
    .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FRAME_BYTES(FRAME_BYTES)
  ) dut (
    .vga_clk     (vga_clk),
    .vga_rst     (vga_rst),
    .vga_req     (vga_req),
    .vga_addr_set(vga_addr_set),
    .usb_req     (usb_req),
    .usb_addr_set(usb_addr_set),
    .cmd         (cmd_if),
    .vga_gnt     (vga_gnt),
    .usb_gnt     (usb_gnt),
    .busy        (busy),
    .drop_err    (drop_err)
  );

  always #5 vga_clk = ~vga_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state: bursts issued since base per requester, last grant, sticky drop.
  int cnt_v   = 0;
  int cnt_u   = 0;
  bit last_m  = 1'b1;
  bit drop_m  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int exp_addr(input int cnt);
    return (cnt * BURST_LEN * 8) % FRAME_BYTES;
  endfunction

  task automatic next_cycle();
    @(posedge vga_clk);
    #1;
    cyc++;
  endtask

  // One transaction from idle: requests in cycle 0, expected issues derived from the
  // latency (2 cycles + stall), the 3-cycle issue spacing and the arbitration rule.
  task automatic run_txn(input bit rv, input bit ru, input int stall, input bit dup,
                         input bit setv, input bit rearm, output logic [ADDR_W-1:0] a1);
    bit w[2];
    int t[2];
    int n, t_v, t_end, k;
    n    = 1;
    t[0] = 2 + stall;
    t[1] = t[0] + 3;
    w[1] = 1'b0;
    if (rv && ru) begin
`ifdef DDR_RD_SCHED_RR_EN
      w[0] = ~last_m;
`else
      w[0] = 1'b0;
`endif
      w[1] = ~w[0];
      n    = 2;
    end else begin
      w[0] = ru;
      if (rearm) n = 2;
    end
    t_v   = (w[0] == 1'b0) ? t[0] : t[1];
    t_end = t[n-1] + 2;
    a1    = '0;
    for (int c = 0; c <= t_end; c++) begin
      vga_req      = (rv && c == 0) || (dup && rv && c == 1) || (rearm && c == t[0]);
      usb_req      = (ru && c == 0) || (dup && ru && c == 1);
      cmd_if.cmd_full = (c >= 2) && (c < 2 + stall);
      vga_addr_set = setv && rv && (c == t_v);
      #1;
      k = -1;
      for (int j = 0; j < n; j++) if (t[j] == c) k = j;
      check("cmd_en", 64'(cmd_if.cmd_en), 64'(k >= 0));
      if (k >= 0) begin
        check("vga_gnt", 64'(vga_gnt), 64'(!w[k]));
        check("usb_gnt", 64'(usb_gnt), 64'(w[k]));
        check("cmd_addr", 64'(cmd_if.cmd_addr), 64'(exp_addr(w[k] ? cnt_u : cnt_v)));
        if (k == 0) a1 = cmd_if.cmd_addr;
        if (w[k]) cnt_u = (cnt_u + 1) % BURSTS;
        else      cnt_v = (cnt_v + 1) % BURSTS;
        if (!w[k] && vga_addr_set) cnt_v = 0;
        last_m = w[k];
      end
      if (c == 1)     check("busy_pend", 64'(busy), 64'(1));
      if (c == t_end) check("busy_idle", 64'(busy), 64'(0));
      next_cycle();
    end
    vga_req = 1'b0; usb_req = 1'b0; vga_addr_set = 1'b0; cmd_if.cmd_full = 1'b0;
    if (dup) drop_m = 1'b1;
    check("drop_err", 64'(drop_err), 64'(drop_m));
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    bit rv, ru, dup, setv, rearm;
    cmd_if.cmd_full = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    check("rst_cmd_en",    64'(cmd_if.cmd_en),    64'(0));
    check("rst_vga_gnt",   64'(vga_gnt),          64'(0));
    check("rst_usb_gnt",   64'(usb_gnt),          64'(0));
    check("rst_busy",      64'(busy),             64'(0));
    check("rst_drop_err",  64'(drop_err),         64'(0));
    check("rst_cmd_addr",  64'(cmd_if.cmd_addr), 64'(0));
    check("rst_cmd_instr", 64'(cmd_if.cmd_instr), 64'(3'b001));
    check("rst_cmd_bl",    64'(cmd_if.cmd_bl),    64'(BURST_LEN - 1));
    vga_rst = 1'b0;
    cyc     = 0;

    while (cyc < 10) next_cycle();
    run_txn(1, 0, 0, 0, 0, 0, a);
    check("first_addr", 64'(a), 64'(0));
    run_txn(1, 0, 0, 0, 0, 0, a);
    check("second_addr", 64'(a), 64'(512));

    run_txn(0, 1, 0, 0, 0, 0, a);
    run_txn(1, 1, 0, 0, 0, 0, a);
    run_txn(1, 0, 0, 0, 0, 0, a);
    run_txn(1, 1, 0, 0, 0, 0, a);

    run_txn(1, 0, 20, 0, 0, 0, a);
    run_txn(1, 0, 0, 1, 0, 0, a);
    run_txn(0, 1, 0, 0, 0, 0, a);
    run_txn(1, 0, 0, 0, 0, 1, a);
    run_txn(1, 0, 0, 0, 1, 0, a);
    run_txn(1, 0, 0, 0, 0, 0, a);
    check("addr_set_rewind", 64'(a), 64'(0));

    for (int i = 0; i < 150; i++) begin
      rv    = ($urandom_range(0, 1) == 1);
      ru    = ($urandom_range(0, 1) == 1);
      if (!rv && !ru) rv = 1'b1;
      dup   = ($urandom_range(0, 7) == 0);
      setv  = rv && ($urandom_range(0, 3) == 0);
      rearm = rv && !ru && !setv && ($urandom_range(0, 3) == 0);
      run_txn(rv, ru, int'($urandom_range(0, 3)), dup, setv, rearm, a);
    end

    vga_addr_set = 1'b1;
    next_cycle();
    vga_addr_set = 1'b0;
    cnt_v = 0;
    for (int i = 0; i < BURSTS; i++) run_txn(1, 0, 0, 0, 0, 0, a);
    run_txn(1, 0, 0, 0, 0, 0, a);
    check("wrap_addr", 64'(a), 64'(0));

    vga_req = 1'b1;
    next_cycle();
    vga_req = 1'b0;
    cmd_if.cmd_full = 1'b1;
    next_cycle();
    next_cycle();
    check("stall_no_en", 64'(cmd_if.cmd_en), 64'(0));
    check("stall_busy",  64'(busy),          64'(1));
    vga_rst = 1'b1;
    #1;
    check("mid_rst_cmd_en",   64'(cmd_if.cmd_en),    64'(0));
    check("mid_rst_vga_gnt",  64'(vga_gnt),          64'(0));
    check("mid_rst_usb_gnt",  64'(usb_gnt),          64'(0));
    check("mid_rst_busy",     64'(busy),             64'(0));
    check("mid_rst_drop_err", 64'(drop_err),         64'(0));
    check("mid_rst_cmd_addr", 64'(cmd_if.cmd_addr), 64'(0));
    next_cycle();
    cmd_if.cmd_full = 1'b0;
    vga_rst = 1'b0;
    cnt_v = 0; cnt_u = 0; last_m = 1'b1; drop_m = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      check("post_rst_no_en", 64'(cmd_if.cmd_en), 64'(0));
    end
    run_txn(1, 1, 0, 0, 0, 0, a);
    check("post_rst_vga_base", 64'(a), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
